// File: rtl/adder_pkg.sv
// Shared types and helpers for the multi-word add sequencer.
package adder_pkg;

    localparam int WORD_W    = 32;
    localparam int MAX_WORDS = 16;
    localparam int MAX_W     = WORD_W * MAX_WORDS;
    localparam int IDX_W     = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seq_state_t;

    // Returns 32-bit word idx of a zero-extended operand vector.
    function automatic logic [WORD_W-1:0] word_sel(input logic [MAX_W-1:0] vec,
                                                   input logic [IDX_W-1:0] idx);
        return vec[idx*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// 32-bit adder slice with carry out and two's-complement overflow.
module ripple_carry_adder
    import adder_pkg::*;
(
    input  logic [WORD_W-1:0] A,
    input  logic [WORD_W-1:0] B,
    input  logic              Cin,
    output logic [WORD_W-1:0] Sum,
    output logic              Cout,
    output logic              Overflow
);

    logic carry_into_msb;

    always_comb begin
        {Cout, Sum}    = {1'b0, A} + {1'b0, B} + {{WORD_W{1'b0}}, Cin};
        // Carry into the MSB is recoverable from the MSB sum bit.
        carry_into_msb = A[WORD_W-1] ^ B[WORD_W-1] ^ Sum[WORD_W-1];
        Overflow       = carry_into_msb ^ Cout;
    end

endmodule

// File: rtl/multiword_add_sequencer.sv
// Sequences one NWORDS*32-bit add through a single 32-bit adder slice, LSW first.
// Optional subtract mode: define ADDSEQ_SUBTRACT_EN to add the op_sub port.
module multiword_add_sequencer
    import adder_pkg::*;
#(
    parameter int NWORDS = 4,
    parameter int W      = WORD_W * NWORDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Cin,
`ifdef ADDSEQ_SUBTRACT_EN
    input  logic         op_sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] Sum,
    output logic         Cout,
    output logic         Overflow,
    output logic         busy
);

    seq_state_t        state, state_nxt;
    logic [IDX_W-1:0]  idx;
    logic              carry;
    logic [W-1:0]      a_reg, b_reg;
    logic [MAX_W-1:0]  a_ext, b_ext;
    logic [WORD_W-1:0] slice_a, slice_b, slice_sum;
    logic              slice_cout, slice_ovf;
    logic              accept, last_word;

    assign accept    = (state == IDLE) && in_valid;
    assign last_word = (idx == IDX_W'(NWORDS - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_word) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign a_ext   = MAX_W'(a_reg);
    assign b_ext   = MAX_W'(b_reg);
    assign slice_a = word_sel(a_ext, idx);
    assign slice_b = word_sel(b_ext, idx);

    ripple_carry_adder u_slice (
        .A        (slice_a),
        .B        (slice_b),
        .Cin      (carry),
        .Sum      (slice_sum),
        .Cout     (slice_cout),
        .Overflow (slice_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            Sum      <= '0;
            Cout     <= 1'b0;
            Overflow <= 1'b0;
        end else if (accept) begin
            idx   <= '0;
            a_reg <= A;
`ifdef ADDSEQ_SUBTRACT_EN
            // Subtract is A + ~B + 1; B is stored pre-inverted.
            b_reg <= op_sub ? ~B : B;
            carry <= op_sub ? 1'b1 : Cin;
`else
            b_reg <= B;
            carry <= Cin;
`endif
        end else if (state == RUN) begin
            for (int w = 0; w < NWORDS; w++)
                if (idx == IDX_W'(w)) Sum[w*WORD_W +: WORD_W] <= slice_sum;
            carry <= slice_cout;
            idx   <= idx + 1'b1;
            if (last_word) begin
                Cout     <= slice_cout;
                Overflow <= slice_ovf;
            end
        end
    end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Scoreboard bench for multiword_add_sequencer at NWORDS=4.
module tb_multiword_add_sequencer;

    localparam int NW = 4;
    localparam int W  = 32 * NW;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready;
    logic [W-1:0] A, B, Sum;
    logic         Cin;
`ifdef ADDSEQ_SUBTRACT_EN
    logic         op_sub;
`endif
    logic         out_valid, out_ready, Cout, Overflow, busy;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    multiword_add_sequencer #(.NWORDS(NW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
`ifdef ADDSEQ_SUBTRACT_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Cout      (Cout),
        .Overflow  (Overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_w();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Present one operation, push its modelled result when it is accepted.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
        logic [W-1:0] bb;
        logic         ci;
        logic [W:0]   full;
        exp_t         e;
        int           k;
        @(negedge clk);
        k = 0;
        while (!in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("in_ready_wait", W'(in_ready), W'(1));
        A = a; B = b; Cin = cin;
`ifdef ADDSEQ_SUBTRACT_EN
        op_sub = sub;
`endif
        in_valid = 1'b1;
        @(posedge clk);
        bb     = sub ? ~b : b;
        ci     = sub ? 1'b1 : cin;
        full   = {1'b0, a} + {1'b0, bb} + (W+1)'(ci);
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        A = rnd_w(); B = rnd_w(); Cin = 1'($urandom);
`ifdef ADDSEQ_SUBTRACT_EN
        op_sub = 1'($urandom);
`endif
    endtask

    // Wait for the result, compare it, hold it under backpressure, then drain.
    task automatic collect(input int hold);
        int   lat;
        exp_t e;
        lat = 0;
        check("busy_run", W'(busy), W'(1));
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("latency", W'(lat), W'(NW));
        check("sb_nonempty", W'(sb.size() > 0), W'(1));
        if (sb.size() == 0) return;
        e = sb.pop_front();
        for (int i = 0; i <= hold; i++) begin
            check("sum", Sum, e.sum);
            check("cout", W'(Cout), W'(e.cout));
            check("ovf", W'(Overflow), W'(e.ovf));
            check("done_in_ready", W'(in_ready), W'(0));
            check("done_out_valid", W'(out_valid), W'(1));
            if (i < hold) begin
                in_valid = 1'b1;
                A = rnd_w(); B = rnd_w();
                @(posedge clk);
                @(negedge clk);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_in_ready", W'(in_ready), W'(1));
        check("idle_out_valid", W'(out_valid), W'(0));
    endtask

    initial begin
        logic [W-1:0] t1_a, max_pos, min_neg, ones;
        t1_a    = {32'h0, {96{1'b1}}};
        max_pos = {1'b0, {(W-1){1'b1}}};
        min_neg = {1'b1, {(W-1){1'b0}}};
        ones    = {W{1'b1}};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; Cin = 1'b0;
`ifdef ADDSEQ_SUBTRACT_EN
        op_sub = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_busy", W'(busy), W'(0));
        check("rst_sum", Sum, '0);
        check("rst_cout_ovf", W'({Cout, Overflow}), W'(0));

        send(t1_a, W'(1), 1'b0, 1'b0);  collect(0);
        check("t1_sum_const", Sum, W'(1) << 96);
        send(max_pos, W'(1), 1'b0, 1'b0); collect(0);
        send(min_neg, min_neg, 1'b0, 1'b0); collect(0);
        send(ones, '0, 1'b1, 1'b0); collect(0);
        send(rnd_w(), rnd_w(), 1'b1, 1'b0); collect(5);

        // Abort an operation after two words have been processed.
        send(t1_a, W'(1), 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check("abort_in_ready", W'(in_ready), W'(1));
        check("abort_out_valid", W'(out_valid), W'(0));
        check("abort_sum", Sum, '0);
        repeat (6) @(negedge clk);
        check("abort_no_result", W'(out_valid), W'(0));
        send(max_pos, W'(1), 1'b0, 1'b0); collect(0);

`ifdef ADDSEQ_SUBTRACT_EN
        send(W'(5), W'(7), 1'b0, 1'b1); collect(0);
        check("sub_sum_const", Sum, {{(W-1){1'b1}}, 1'b0});
        send(rnd_w(), rnd_w(), 1'b0, 1'b1); collect(1);
`endif

        for (int i = 0; i < 4; i++) begin
            send(rnd_w(), rnd_w(), 1'($urandom), 1'b0);
            collect(i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
